// File: rtl/recovery_sequencer_if.sv
// Bundle of signals between the recovery sequencer and the rest of the core.
// The sequencer uses the slave modport; the core (or a bench) uses the master modport.
interface recovery_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
);
  logic              mispredict_i;
  logic [ADDR_W-1:0] mispred_target_i;
  logic              fu_busy_i;
  logic              mem_busy_i;
  logic              fetch_ready_i;
  logic              flush_o;
  logic              restore_map_o;
  logic              restore_freelist_o;
  logic              stall_dispatch_o;
  logic              redirect_valid_o;
  logic [ADDR_W-1:0] redirect_pc_o;
  logic              busy_o;
  logic              drain_timeout_o;
  logic [CNT_W-1:0]  recovery_count_o;

  modport slave (
    input  mispredict_i, mispred_target_i, fu_busy_i, mem_busy_i, fetch_ready_i,
    output flush_o, restore_map_o, restore_freelist_o, stall_dispatch_o,
           redirect_valid_o, redirect_pc_o, busy_o, drain_timeout_o, recovery_count_o
  );

  modport master (
    output mispredict_i, mispred_target_i, fu_busy_i, mem_busy_i, fetch_ready_i,
    input  flush_o, restore_map_o, restore_freelist_o, stall_dispatch_o,
           redirect_valid_o, redirect_pc_o, busy_o, drain_timeout_o, recovery_count_o
  );
endinterface

// File: rtl/recovery_sequencer.sv
// Branch-mispredict recovery controller: flush -> map/freelist restore -> drain
// of in-flight ops -> fetch redirect. Dispatch is held stalled throughout.
module recovery_sequencer #(
  parameter int FLUSH_CYCLES  = 2,
  parameter int DRAIN_TIMEOUT = 256,
  parameter int CNT_W         = 32,
  parameter int ADDR_W        = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  recovery_sequencer_if.slave  bus
);

  // One counter serves both the FLUSH and DRAIN phases, so size it for the larger.
  localparam int CYC_MAX = (FLUSH_CYCLES > DRAIN_TIMEOUT) ? FLUSH_CYCLES : DRAIN_TIMEOUT;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);
  localparam logic [CYC_W-1:0] FLUSH_LAST = CYC_W'(FLUSH_CYCLES - 1);
  localparam logic [CYC_W-1:0] DRAIN_LAST = CYC_W'(DRAIN_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FLUSH    = 3'd1,
    RESTORE  = 3'd2,
    DRAIN    = 3'd3,
    REDIRECT = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [CYC_W-1:0]  cyc, cyc_nxt;
  logic [ADDR_W-1:0] target, target_nxt;
  logic              timeout_flag, timeout_nxt;
  logic [CNT_W-1:0]  count, count_nxt;

  // State, phase counter, latched target, sticky timeout flag and recovery count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cyc          <= '0;
      target       <= '0;
      timeout_flag <= 1'b0;
      count        <= '0;
    end else begin
      state        <= state_nxt;
      cyc          <= cyc_nxt;
      target       <= target_nxt;
      timeout_flag <= timeout_nxt;
      count        <= count_nxt;
    end
  end

  // Next-state sequencing; a mispredict is only accepted from IDLE so the
  // target of an in-progress recovery can never be overwritten.
  always_comb begin
    state_nxt   = state;
    cyc_nxt     = cyc;
    target_nxt  = target;
    timeout_nxt = timeout_flag;
    count_nxt   = count;
    case (state)
      IDLE: begin
        if (bus.mispredict_i) begin
          target_nxt = bus.mispred_target_i;
          cyc_nxt    = '0;
          state_nxt  = FLUSH;
        end
      end
      FLUSH: begin
        cyc_nxt = cyc + 1'b1;
        if (cyc == FLUSH_LAST) begin
          state_nxt = RESTORE;
        end
      end
      RESTORE: begin
        cyc_nxt   = '0;
        state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!bus.fu_busy_i && !bus.mem_busy_i) begin
          state_nxt = REDIRECT;
        end else if (cyc == DRAIN_LAST) begin
          timeout_nxt = 1'b1;
          state_nxt   = REDIRECT;
        end else begin
          cyc_nxt = cyc + 1'b1;
        end
      end
      REDIRECT: begin
        if (bus.fetch_ready_i) begin
          count_nxt = count + 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Moore outputs decoded from the registered state.
  assign bus.flush_o            = (state == FLUSH);
  assign bus.restore_map_o      = (state == RESTORE);
  assign bus.restore_freelist_o = (state == RESTORE);
  assign bus.redirect_valid_o   = (state == REDIRECT);
  assign bus.redirect_pc_o      = (state == REDIRECT) ? target : '0;
  assign bus.busy_o             = (state != IDLE);
  assign bus.drain_timeout_o    = timeout_flag;
  assign bus.recovery_count_o   = count;

  // Stall reacts to the mispredict in the same cycle so nothing younger dispatches;
  // it is forced low while reset is asserted.
  assign bus.stall_dispatch_o = !reset &&
                                ((state != IDLE) || ((state == IDLE) && bus.mispredict_i));

endmodule

// File: tb/tb_recovery_sequencer.sv
// Bench for recovery_sequencer: scenario tasks with a redirect-target scoreboard
// and a bench-side model of the recovery count.
module tb_recovery_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b1;

  recovery_sequencer_if #(.ADDR_W(32), .CNT_W(32)) bus ();

  recovery_sequencer #(
    .FLUSH_CYCLES (2),
    .DRAIN_TIMEOUT(8),
    .CNT_W        (32),
    .ADDR_W       (32)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          fails  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;
  int          exp_count = 0;

  // {flush, restore_map, restore_freelist, stall, redirect_valid, busy, drain_timeout}
  function automatic logic [6:0] ctl();
    return {bus.flush_o, bus.restore_map_o, bus.restore_freelist_o, bus.stall_dispatch_o,
            bus.redirect_valid_o, bus.busy_o, bus.drain_timeout_o};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    bus.mispredict_i = 1'b0; bus.mispred_target_i = '0; bus.fu_busy_i = 1'b0;
    bus.mem_busy_i = 1'b0; bus.fetch_ready_i = 1'b0;
    reset = 1'b1;
    repeat (3) step();
    checks++;
    if (ctl() !== 7'b0 || bus.redirect_pc_o !== 32'h0 || bus.recovery_count_o !== 32'h0) begin
      fails++; $display("FAIL reset_hold: ctl=%b pc=%h cnt=%0d, want all 0", ctl(), bus.redirect_pc_o, bus.recovery_count_o);
    end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (ctl() !== 7'b0 || bus.redirect_pc_o !== 32'h0 || bus.recovery_count_o !== 32'h0) begin
        fails++; $display("FAIL reset_idle[%0d]: ctl=%b pc=%h cnt=%0d, want all 0", i, ctl(), bus.redirect_pc_o, bus.recovery_count_o);
      end
    end
  endtask

  task automatic test_basic();
    bus.fetch_ready_i = 1'b1; bus.mispredict_i = 1'b1; bus.mispred_target_i = 32'h1000;
    exp_q.push_back(32'h1000); exp_count++;
    #1;
    checks++;
    if (ctl() !== 7'b0001000) begin fails++; $display("FAIL basic_stall_comb: ctl=%b want %b", ctl(), 7'b0001000); end
    step(); bus.mispredict_i = 1'b0; #1;
    checks++;
    if (ctl() !== 7'b1001010) begin fails++; $display("FAIL basic_flush1: ctl=%b want %b", ctl(), 7'b1001010); end
    step();
    checks++;
    if (ctl() !== 7'b1001010) begin fails++; $display("FAIL basic_flush2: ctl=%b want %b", ctl(), 7'b1001010); end
    step();
    checks++;
    if (ctl() !== 7'b0111010) begin fails++; $display("FAIL basic_restore: ctl=%b want %b", ctl(), 7'b0111010); end
    step();
    checks++;
    if (ctl() !== 7'b0001010) begin fails++; $display("FAIL basic_drain: ctl=%b want %b", ctl(), 7'b0001010); end
    step();
    checks++;
    if (ctl() !== 7'b0001110) begin fails++; $display("FAIL basic_redirect: ctl=%b want %b", ctl(), 7'b0001110); end
    checks++;
    if (exp_q.size() == 0 || bus.redirect_pc_o !== exp_q[0]) begin
      fails++; $display("FAIL basic_pc: pc=%h want %h", bus.redirect_pc_o, (exp_q.size() != 0) ? exp_q[0] : 32'hx);
    end
    if (exp_q.size() != 0) exp_pc = exp_q.pop_front();
    step();
    checks++;
    if (ctl() !== 7'b0 || bus.redirect_pc_o !== 32'h0 || bus.recovery_count_o !== 32'(exp_count)) begin
      fails++; $display("FAIL basic_done: ctl=%b pc=%h cnt=%0d want 0/0/%0d", ctl(), bus.redirect_pc_o, bus.recovery_count_o, exp_count);
    end
  endtask

  task automatic test_mem_busy();
    bus.mem_busy_i = 1'b1; bus.fetch_ready_i = 1'b0; bus.mispredict_i = 1'b1; bus.mispred_target_i = 32'h1400;
    exp_q.push_back(32'h1400); exp_count++;
    step(); bus.mispredict_i = 1'b0;
    step(); step(); step();
    checks++;
    if (ctl() !== 7'b0001010) begin fails++; $display("FAIL mem_drain_entry: ctl=%b want %b", ctl(), 7'b0001010); end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (ctl() !== 7'b0001010) begin fails++; $display("FAIL mem_drain_hold[%0d]: ctl=%b want %b", i, ctl(), 7'b0001010); end
    end
    bus.mem_busy_i = 1'b0;
    step();
    checks++;
    if (exp_q.size() == 0) begin
      fails++; $display("FAIL mem_pc: pc=%h want queued target (queue empty)", bus.redirect_pc_o);
    end else begin
      exp_pc = exp_q.pop_front();
      if (ctl() !== 7'b0001110 || bus.redirect_pc_o !== exp_pc) begin
        fails++; $display("FAIL mem_redirect: ctl=%b pc=%h want %b/%h", ctl(), bus.redirect_pc_o, 7'b0001110, exp_pc);
      end
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (bus.redirect_valid_o !== 1'b1 || bus.redirect_pc_o !== exp_pc) begin
        fails++; $display("FAIL mem_pc_stable[%0d]: valid=%b pc=%h want 1/%h", i, bus.redirect_valid_o, bus.redirect_pc_o, exp_pc);
      end
    end
    bus.fetch_ready_i = 1'b1; #1;
    checks++;
    if (bus.redirect_valid_o !== 1'b1 || bus.redirect_pc_o !== exp_pc) begin
      fails++; $display("FAIL mem_pc_hs: valid=%b pc=%h want 1/%h", bus.redirect_valid_o, bus.redirect_pc_o, exp_pc);
    end
    step();
    checks++;
    if (ctl() !== 7'b0 || bus.recovery_count_o !== 32'(exp_count)) begin
      fails++; $display("FAIL mem_done: ctl=%b cnt=%0d want 0/%0d", ctl(), bus.recovery_count_o, exp_count);
    end
  endtask

  task automatic test_timeout();
    int n;
    bus.fu_busy_i = 1'b1; bus.fetch_ready_i = 1'b1; bus.mispredict_i = 1'b1; bus.mispred_target_i = 32'h1800;
    exp_q.push_back(32'h1800); exp_count++;
    step(); bus.mispredict_i = 1'b0;
    step(); step(); step();
    checks++;
    if (ctl() !== 7'b0001010) begin fails++; $display("FAIL tmo_drain_entry: ctl=%b want %b", ctl(), 7'b0001010); end
    n = 1;
    while (bus.redirect_valid_o !== 1'b1 && n < 40) begin
      step();
      if (bus.redirect_valid_o !== 1'b1) n++;
    end
    checks++;
    if (n != 8 || bus.redirect_valid_o !== 1'b1) begin
      fails++; $display("FAIL tmo_drain_len: drain cycles=%0d valid=%b want 8/1", n, bus.redirect_valid_o);
    end
    checks++;
    if (exp_q.size() == 0) begin
      fails++; $display("FAIL tmo_redirect: pc=%h want queued target (queue empty)", bus.redirect_pc_o);
    end else begin
      exp_pc = exp_q.pop_front();
      if (ctl() !== 7'b0001111 || bus.redirect_pc_o !== exp_pc) begin
        fails++; $display("FAIL tmo_redirect: ctl=%b pc=%h want %b/%h", ctl(), bus.redirect_pc_o, 7'b0001111, exp_pc);
      end
    end
    step();
    checks++;
    if (ctl() !== 7'b0000001 || bus.recovery_count_o !== 32'(exp_count)) begin
      fails++; $display("FAIL tmo_done: ctl=%b cnt=%0d want %b/%0d", ctl(), bus.recovery_count_o, 7'b0000001, exp_count);
    end
    bus.fu_busy_i = 1'b0; bus.mispredict_i = 1'b1; bus.mispred_target_i = 32'h1c00;
    exp_q.push_back(32'h1c00); exp_count++;
    step(); bus.mispredict_i = 1'b0;
    step(); step(); step(); step();
    checks++;
    if (exp_q.size() == 0) begin
      fails++; $display("FAIL tmo_sticky_redirect: pc=%h want queued target (queue empty)", bus.redirect_pc_o);
    end else begin
      exp_pc = exp_q.pop_front();
      if (ctl() !== 7'b0001111 || bus.redirect_pc_o !== exp_pc) begin
        fails++; $display("FAIL tmo_sticky_redirect: ctl=%b pc=%h want %b/%h", ctl(), bus.redirect_pc_o, 7'b0001111, exp_pc);
      end
    end
    step();
    checks++;
    if (ctl() !== 7'b0000001 || bus.recovery_count_o !== 32'(exp_count)) begin
      fails++; $display("FAIL tmo_sticky_done: ctl=%b cnt=%0d want %b/%0d", ctl(), bus.recovery_count_o, 7'b0000001, exp_count);
    end
  endtask

  task automatic test_ignore();
    reset = 1'b1; step(); reset = 1'b0;
    exp_q.delete(); exp_count = 0;
    checks++;
    if (ctl() !== 7'b0 || bus.recovery_count_o !== 32'h0) begin
      fails++; $display("FAIL ign_reset: ctl=%b cnt=%0d want 0/0", ctl(), bus.recovery_count_o);
    end
    bus.fetch_ready_i = 1'b0; bus.mispredict_i = 1'b1; bus.mispred_target_i = 32'h1000;
    exp_q.push_back(32'h1000); exp_count++;
    step(); bus.mispred_target_i = 32'h2000; #1;
    checks++;
    if (ctl() !== 7'b1001010) begin fails++; $display("FAIL ign_flush: ctl=%b want %b", ctl(), 7'b1001010); end
    step(); bus.mispredict_i = 1'b0;
    step(); step(); step();
    bus.mispredict_i = 1'b1; bus.mispred_target_i = 32'h2000; bus.fetch_ready_i = 1'b1; #1;
    checks++;
    if (exp_q.size() == 0) begin
      fails++; $display("FAIL ign_pc: pc=%h want queued target (queue empty)", bus.redirect_pc_o);
    end else begin
      exp_pc = exp_q.pop_front();
      if (ctl() !== 7'b0001110 || bus.redirect_pc_o !== exp_pc) begin
        fails++; $display("FAIL ign_pc: ctl=%b pc=%h want %b/%h", ctl(), bus.redirect_pc_o, 7'b0001110, exp_pc);
      end
    end
    step(); bus.mispredict_i = 1'b0; bus.fetch_ready_i = 1'b0; #1;
    checks++;
    if (ctl() !== 7'b0 || bus.recovery_count_o !== 32'(exp_count)) begin
      fails++; $display("FAIL ign_done: ctl=%b cnt=%0d want 0/%0d", ctl(), bus.recovery_count_o, exp_count);
    end
    step(); step();
    checks++;
    if (ctl() !== 7'b0 || bus.recovery_count_o !== 32'(exp_count)) begin
      fails++; $display("FAIL ign_stays_idle: ctl=%b cnt=%0d want 0/%0d", ctl(), bus.recovery_count_o, exp_count);
    end
  endtask

  task automatic test_reset_mid();
    bus.fu_busy_i = 1'b1; bus.fetch_ready_i = 1'b1; bus.mispredict_i = 1'b1; bus.mispred_target_i = 32'h2400;
    exp_q.push_back(32'h2400);
    step(); bus.mispredict_i = 1'b0;
    step(); step(); step(); step();
    checks++;
    if (ctl() !== 7'b0001010) begin fails++; $display("FAIL rmid_in_drain: ctl=%b want %b", ctl(), 7'b0001010); end
    reset = 1'b1; #1;
    checks++;
    if (ctl() !== 7'b0 || bus.redirect_pc_o !== 32'h0 || bus.recovery_count_o !== 32'h0) begin
      fails++; $display("FAIL rmid_async: ctl=%b pc=%h cnt=%0d want all 0", ctl(), bus.redirect_pc_o, bus.recovery_count_o);
    end
    exp_q.delete(); exp_count = 0;
    step(); reset = 1'b0; bus.fu_busy_i = 1'b0;
    bus.mispredict_i = 1'b1; bus.mispred_target_i = 32'h3000;
    exp_q.push_back(32'h3000); exp_count++;
    step(); bus.mispredict_i = 1'b0; #1;
    checks++;
    if (ctl() !== 7'b1001010) begin fails++; $display("FAIL rmid_flush1: ctl=%b want %b", ctl(), 7'b1001010); end
    step();
    checks++;
    if (ctl() !== 7'b1001010) begin fails++; $display("FAIL rmid_flush2: ctl=%b want %b", ctl(), 7'b1001010); end
    step();
    checks++;
    if (ctl() !== 7'b0111010) begin fails++; $display("FAIL rmid_restore: ctl=%b want %b", ctl(), 7'b0111010); end
    step(); step();
    checks++;
    if (exp_q.size() == 0) begin
      fails++; $display("FAIL rmid_redirect: pc=%h want queued target (queue empty)", bus.redirect_pc_o);
    end else begin
      exp_pc = exp_q.pop_front();
      if (ctl() !== 7'b0001110 || bus.redirect_pc_o !== exp_pc) begin
        fails++; $display("FAIL rmid_redirect: ctl=%b pc=%h want %b/%h", ctl(), bus.redirect_pc_o, 7'b0001110, exp_pc);
      end
    end
    step();
    checks++;
    if (ctl() !== 7'b0 || bus.recovery_count_o !== 32'(exp_count)) begin
      fails++; $display("FAIL rmid_done: ctl=%b cnt=%0d want 0/%0d", ctl(), bus.recovery_count_o, exp_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mem_busy();
    test_timeout();
    test_ignore();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want all scenarios complete");
    $fatal(1, "watchdog expired");
  end

endmodule
